// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/load result producers, the write-back arbiter
// and the register file write port.
interface wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_dst;
    logic [31:0] ld_data;
    logic        reg_we;
    logic [4:0]  dstreg_num;
    logic [31:0] dstreg_data;
    logic [31:0] busy_mask;

    modport slave (
        input  alu_valid, alu_dst, alu_data, ld_valid, ld_dst, ld_data,
        output alu_ready, ld_ready, reg_we, dstreg_num, dstreg_data, busy_mask
    );

    modport master (
        output alu_valid, alu_dst, alu_data, ld_valid, ld_dst, ld_data,
        input  alu_ready, ld_ready, reg_we, dstreg_num, dstreg_data, busy_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: serialises ALU results and FIFO-buffered load results
// onto one register-file write port, with hazard blocking and anti-starvation.
module wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    logic [4:0]            fifo_dst  [FIFO_DEPTH];
    logic [31:0]           fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_live;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [OCC_W-1:0]      occ;
    logic [CNT_W-1:0]      starve_cnt;

    logic        we_q;
    logic [4:0]  num_q;
    logic [31:0] data_q;

    logic        fifo_nonempty;
    logic        hazard;
    logic        starved;
    logic        alu_fire;
    logic        enq;
    logic        deq;
    logic [31:0] busy;

    assign fifo_nonempty = (occ != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hazard = 1'b0;
        busy   = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_live[i]) begin
                if (fifo_dst[i] == bus.alu_dst) hazard = 1'b1;
                busy[fifo_dst[i]] = 1'b1;
            end
        end
        if (bus.alu_dst == 5'd0) hazard = 1'b0;
        if (we_q) busy[num_q] = 1'b1;
        busy[0] = 1'b0;
    end

    assign starved       = (starve_cnt == LIMIT_CNT) && fifo_nonempty;
    assign bus.alu_ready = !rst && !hazard && !starved;
    assign bus.ld_ready  = !rst && (occ < DEPTH_OCC);

    // The ALU has priority; the FIFO head goes out whenever the ALU does not fire.
    assign alu_fire = bus.alu_valid && bus.alu_ready;
    assign deq      = !alu_fire && fifo_nonempty;
    assign enq      = bus.ld_valid && bus.ld_ready && (bus.ld_dst != 5'd0);

    assign bus.reg_we      = we_q;
    assign bus.dstreg_num  = num_q;
    assign bus.dstreg_data = data_q;
    assign bus.busy_mask   = busy;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            fifo_live  <= '0;
            starve_cnt <= '0;
            we_q       <= 1'b0;
            num_q      <= '0;
            data_q     <= '0;
        end else begin
            if (enq) begin
                wr_ptr            <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                fifo_live[wr_ptr] <= 1'b1;
            end
            if (deq) begin
                rd_ptr            <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                fifo_live[rd_ptr] <= 1'b0;
            end
            if (enq && !deq)      occ <= occ + 1'b1;
            else if (deq && !enq) occ <= occ - 1'b1;

            if (deq || !fifo_nonempty)
                starve_cnt <= '0;
            else if (alu_fire && starve_cnt != LIMIT_CNT)
                starve_cnt <= starve_cnt + 1'b1;

            if (alu_fire) begin
                we_q <= (bus.alu_dst != 5'd0);
                if (bus.alu_dst != 5'd0) begin
                    num_q  <= bus.alu_dst;
                    data_q <= bus.alu_data;
                end
            end else if (deq) begin
                we_q   <= 1'b1;
                num_q  <= fifo_dst[rd_ptr];
                data_q <= fifo_data[rd_ptr];
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    // NOTE: payload storage is not reset; fifo_live qualifies every entry.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_dst[wr_ptr]  <= bus.ld_dst;
            fifo_data[wr_ptr] <= bus.ld_data;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    logic clk;
    logic rst;
    wb_arbiter_if bus();

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    ent_t        mq[$];
    int          m_starve;
    bit          m_we;
    logic [4:0]  m_num;
    logic [31:0] m_data;

    bit e_alu_ready, e_ld_ready;
    bit o_alu_ready, o_ld_ready;

    function automatic bit m_hazard(input logic [4:0] d);
        if (d == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].dst == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (mq[i]) b[mq[i].dst] = 1'b1;
        if (m_we) b[m_num] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    // One clock: drive inputs, sample readies mid-cycle, advance model at the edge.
    task automatic tick(input bit r, input bit av, input logic [4:0] ad, input logic [31:0] adt,
                        input bit lv, input logic [4:0] ldd, input logic [31:0] ldt);
        int pre_size;
        rst           = r;
        bus.alu_valid = av;
        bus.alu_dst   = ad;
        bus.alu_data  = adt;
        bus.ld_valid  = lv;
        bus.ld_dst    = ldd;
        bus.ld_data   = ldt;
        e_alu_ready = !r && !m_hazard(ad) && !(m_starve == LIMIT && mq.size() != 0);
        e_ld_ready  = !r && (mq.size() < DEPTH);
        #1;
        o_alu_ready = bus.alu_ready;
        o_ld_ready  = bus.ld_ready;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_starve = 0;
            m_we     = 1'b0;
            m_num    = '0;
            m_data   = '0;
        end else begin
            pre_size = mq.size();
            m_we = 1'b0;
            if (av && e_alu_ready) begin
                if (ad != 5'd0) begin
                    m_we = 1'b1; m_num = ad; m_data = adt;
                end
                if (pre_size == 0) m_starve = 0;
                else if (m_starve < LIMIT) m_starve++;
            end else if (pre_size != 0) begin
                m_we = 1'b1; m_num = mq[0].dst; m_data = mq[0].data;
                void'(mq.pop_front());
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
            if (lv && e_ld_ready && ldd != 5'd0) mq.push_back('{dst: ldd, data: ldt});
        end
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        total++; if (o_alu_ready !== 1'b0) begin bad++; $display("FAIL reset_alu_ready: got %b want 0", o_alu_ready); end
        total++; if (o_ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready: got %b want 0", o_ld_ready); end
        total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bus.reg_we); end
        total++; if (bus.dstreg_num !== 5'd0) begin bad++; $display("FAIL reset_num: got %0d want 0", bus.dstreg_num); end
        total++; if (bus.dstreg_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.dstreg_data); end
        total++; if (bus.busy_mask !== 32'd0) begin bad++; $display("FAIL reset_busy: got %h want 0", bus.busy_mask); end
        idle();
        total++; if (o_ld_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ld_ready: got %b want 1", o_ld_ready); end
        total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL reset_no_write: got %b want 0", bus.reg_we); end
    endtask

    task automatic test_alu_only();
        do_reset();
        tick(1'b0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'd0);
        total++; if (o_alu_ready !== 1'b1) begin bad++; $display("FAIL alu_only_ready: got %b want 1", o_alu_ready); end
        total++; if (bus.reg_we !== 1'b1) begin bad++; $display("FAIL alu_only_we: got %b want 1", bus.reg_we); end
        total++; if (bus.dstreg_num !== 5'd3) begin bad++; $display("FAIL alu_only_num: got %0d want 3", bus.dstreg_num); end
        total++; if (bus.dstreg_data !== 32'h12345678) begin bad++; $display("FAIL alu_only_data: got %h want 12345678", bus.dstreg_data); end
        total++; if (bus.busy_mask !== 32'h8) begin bad++; $display("FAIL alu_only_busy: got %h want 00000008", bus.busy_mask); end
        idle();
        total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL alu_only_idle_we: got %b want 0", bus.reg_we); end
        total++; if (bus.dstreg_num !== 5'd3) begin bad++; $display("FAIL alu_only_hold_num: got %0d want 3", bus.dstreg_num); end
        total++; if (bus.dstreg_data !== 32'h12345678) begin bad++; $display("FAIL alu_only_hold_data: got %h want 12345678", bus.dstreg_data); end
    endtask

    task automatic test_contention();
        do_reset();
        tick(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 32'hAAAA0000);
        total++; if (bus.dstreg_num !== 5'd6 || bus.reg_we !== 1'b1) begin bad++; $display("FAIL contention_alu_first: got we=%b num=%0d want we=1 num=6", bus.reg_we, bus.dstreg_num); end
        total++; if (bus.busy_mask !== 32'h60) begin bad++; $display("FAIL contention_busy: got %h want 00000060", bus.busy_mask); end
        idle();
        total++; if (bus.reg_we !== 1'b1 || bus.dstreg_num !== 5'd5) begin bad++; $display("FAIL contention_ld_second: got we=%b num=%0d want we=1 num=5", bus.reg_we, bus.dstreg_num); end
        total++; if (bus.dstreg_data !== 32'hAAAA0000) begin bad++; $display("FAIL contention_ld_data: got %h want aaaa0000", bus.dstreg_data); end
        total++; if (bus.busy_mask !== 32'h20) begin bad++; $display("FAIL contention_busy2: got %h want 00000020", bus.busy_mask); end
        idle();
        total++; if (bus.reg_we !== 1'b0 || bus.busy_mask !== 32'd0) begin bad++; $display("FAIL contention_drain: got we=%b busy=%h want we=0 busy=0", bus.reg_we, bus.busy_mask); end
    endtask

    task automatic test_hazard();
        do_reset();
        tick(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h77);
        tick(1'b0, 1'b1, 5'd7, 32'hA7, 1'b0, 5'd0, 32'd0);
        total++; if (o_alu_ready !== 1'b0) begin bad++; $display("FAIL hazard_block: got %b want 0", o_alu_ready); end
        total++; if (bus.dstreg_num !== 5'd7 || bus.dstreg_data !== 32'h77) begin bad++; $display("FAIL hazard_load_first: got num=%0d data=%h want num=7 data=00000077", bus.dstreg_num, bus.dstreg_data); end
        tick(1'b0, 1'b1, 5'd7, 32'hA7, 1'b0, 5'd0, 32'd0);
        total++; if (o_alu_ready !== 1'b1) begin bad++; $display("FAIL hazard_release: got %b want 1", o_alu_ready); end
        total++; if (bus.reg_we !== 1'b1 || bus.dstreg_data !== 32'hA7) begin bad++; $display("FAIL hazard_alu_last: got we=%b data=%h want we=1 data=000000a7", bus.reg_we, bus.dstreg_data); end
    endtask

    task automatic test_starvation();
        do_reset();
        tick(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < LIMIT; i++) begin
            tick(1'b0, 1'b1, 5'(10 + i), 32'(i), 1'b0, 5'd0, 32'd0);
            total++; if (o_alu_ready !== 1'b1 || bus.dstreg_num !== 5'(10 + i)) begin bad++; $display("FAIL starve_alu_win%0d: got ready=%b num=%0d want ready=1 num=%0d", i, o_alu_ready, bus.dstreg_num, 10 + i); end
        end
        tick(1'b0, 1'b1, 5'd14, 32'hE, 1'b0, 5'd0, 32'd0);
        total++; if (o_alu_ready !== 1'b0) begin bad++; $display("FAIL starve_force: got %b want 0", o_alu_ready); end
        total++; if (bus.dstreg_num !== 5'd9 || bus.dstreg_data !== 32'h99) begin bad++; $display("FAIL starve_load_out: got num=%0d data=%h want num=9 data=00000099", bus.dstreg_num, bus.dstreg_data); end
        tick(1'b0, 1'b1, 5'd14, 32'hE, 1'b0, 5'd0, 32'd0);
        total++; if (o_alu_ready !== 1'b1 || bus.dstreg_num !== 5'd14) begin bad++; $display("FAIL starve_resume: got ready=%b num=%0d want ready=1 num=14", o_alu_ready, bus.dstreg_num); end
    endtask

    task automatic test_full_dst0();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b0, 1'b1, 5'(1 + i), 32'(i), 1'b1, 5'(20 + i), 32'(100 + i));
            total++; if (o_ld_ready !== 1'b1) begin bad++; $display("FAIL full_fill%0d_ld_ready: got %b want 1", i, o_ld_ready); end
        end
        total++; if (bus.busy_mask !== 32'h00F00010) begin bad++; $display("FAIL full_busy: got %h want 00f00010", bus.busy_mask); end
        tick(1'b0, 1'b1, 5'd5, 32'h5, 1'b1, 5'd24, 32'h124);
        total++; if (o_ld_ready !== 1'b0) begin bad++; $display("FAIL full_ld_ready: got %b want 0", o_ld_ready); end
        total++; if (o_alu_ready !== 1'b1) begin bad++; $display("FAIL full_alu_ready: got %b want 1", o_alu_ready); end
        tick(1'b0, 1'b1, 5'd6, 32'h6, 1'b0, 5'd0, 32'd0);
        total++; if (o_alu_ready !== 1'b0 || bus.dstreg_num !== 5'd20) begin bad++; $display("FAIL full_forced_head: got ready=%b num=%0d want ready=0 num=20", o_alu_ready, bus.dstreg_num); end
        do_reset();
        tick(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        total++; if (o_alu_ready !== 1'b1 || o_ld_ready !== 1'b1) begin bad++; $display("FAIL dst0_accept: got alu=%b ld=%b want 1 1", o_alu_ready, o_ld_ready); end
        total++; if (bus.reg_we !== 1'b0 || bus.busy_mask !== 32'd0) begin bad++; $display("FAIL dst0_discard: got we=%b busy=%h want we=0 busy=0", bus.reg_we, bus.busy_mask); end
        idle();
        total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL dst0_no_fifo: got %b want 0", bus.reg_we); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 5'(1 + i), 32'(i), 1'b1, 5'(7 + i), 32'(70 + i));
        total++; if (bus.busy_mask !== 32'h388) begin bad++; $display("FAIL midrun_busy: got %h want 00000388", bus.busy_mask); end
        tick(1'b1, 1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13);
        total++; if (bus.reg_we !== 1'b0 || bus.busy_mask !== 32'd0) begin bad++; $display("FAIL midrun_flush: got we=%b busy=%h want we=0 busy=0", bus.reg_we, bus.busy_mask); end
        idle();
        total++; if (o_ld_ready !== 1'b1) begin bad++; $display("FAIL midrun_ld_ready: got %b want 1", o_ld_ready); end
        total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL midrun_no_write: got %b want 0", bus.reg_we); end
    endtask

    task automatic test_random();
        bit r, av, lv;
        logic [4:0] ad, ldd;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            r   = ($urandom_range(0, 99) == 0);
            av  = ($urandom_range(0, 3) != 0);
            lv  = ($urandom_range(0, 1) != 0);
            ad  = 5'($urandom_range(0, 7));
            ldd = 5'($urandom_range(0, 7));
            tick(r, av, ad, $urandom, lv, ldd, $urandom);
            total++; if (o_alu_ready !== e_alu_ready) begin bad++; $display("FAIL rand_alu_ready@%0d: got %b want %b", c, o_alu_ready, e_alu_ready); end
            total++; if (o_ld_ready !== e_ld_ready) begin bad++; $display("FAIL rand_ld_ready@%0d: got %b want %b", c, o_ld_ready, e_ld_ready); end
            total++; if (bus.reg_we !== m_we) begin bad++; $display("FAIL rand_we@%0d: got %b want %b", c, bus.reg_we, m_we); end
            total++; if (bus.dstreg_num !== m_num) begin bad++; $display("FAIL rand_num@%0d: got %0d want %0d", c, bus.dstreg_num, m_num); end
            total++; if (bus.dstreg_data !== m_data) begin bad++; $display("FAIL rand_data@%0d: got %h want %h", c, bus.dstreg_data, m_data); end
            total++; if (bus.busy_mask !== m_busy()) begin bad++; $display("FAIL rand_busy@%0d: got %h want %h", c, bus.busy_mask, m_busy()); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_dst   = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_dst    = '0;
        bus.ld_data   = '0;
        m_starve = 0;
        m_we     = 1'b0;
        m_num    = '0;
        m_data   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu_only();
        test_contention();
        test_hazard();
        test_starvation();
        test_full_dst0();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
